demux_burst_scheduler: RTL and testbench
========================================

# demux_burst_scheduler

Controller that shares a serial 1-bit input stream between four sinks through the team's 1-to-4 demultiplexer. It arbitrates round-robin among sink requests and holds the selected route for a fixed burst of transferred bits. It drives the demux select and active-low enable, and gives the source a valid/ready handshake. It sits between the upstream bit source and the demux instance; the 1-to-8 build uses two instances plus a top-level select bit.

## Interface
- BURST, 4: bits transferred per grant; legal range 1..16
- CNT_W, derived $clog2(BURST+1): burst counter width
- clk  in  1  rising-edge clock; the block's only clock
- rst  in  1  synchronous, active-high reset
- req  in  4  per-sink request/ready; bit k high means sink k can accept a bit this cycle
- in_valid  in  1  source presents a valid bit on the demux data input this cycle
- in_ready  out  1  a bit is accepted this cycle when in_valid && in_ready
- S  out  2  demux select, index of the granted sink
- En  out  1  demux enable, active-low: 0 routes data, 1 forces all demux outputs to 0
- grant  out  4  one-hot granted sink; 0 when idle
- out_valid  out  4  per-sink beat strobe = grant & {4{in_valid && in_ready}}
- busy  out  1  high while a burst is open (state GRANT)

## Operation
- States: IDLE, GRANT.
- Reset values: state=IDLE, En=1, S=0, grant=0, busy=0, in_ready=0, out_valid=0, beat counter=0, rr pointer=3, so sink 0 has first priority.
- IDLE: En=1, in_ready=0. If req≠0, the arbiter picks the first set bit in order ptr+1, ptr+2, ptr+3, ptr (mod 4). On the next edge: S=idx, grant=onehot(idx), En=0, busy=1, counter=0, ptr=idx, state=GRANT. If req=0, the block stays in IDLE.
- GRANT: in_ready = req[S], combinational. A beat is any cycle with in_valid && in_ready; each beat increments the counter.
- Beat that makes count==BURST: on the next edge state=IDLE, En=1, grant=0, busy=0, counter=0. S holds its last value.
- Stall: if the granted sink drops req, in_ready=0 and the counter holds. S, En and grant stay unchanged. The burst resumes when req returns. There is no timeout and no pre-emption.
- Requests from non-granted sinks are ignored until the block returns to IDLE.
- rst asserted in any state, including mid-burst: reset values apply at the next edge. The partial burst is discarded and the pointer resets.
- A sink samples the demux output only on its out_valid bit. Outside beats, the demux output content is don't-care.

## Timing
- S, En, grant, busy and the counter are registered. in_ready and out_valid are combinational from state, req, S and in_valid.
- Arbitration latency: req seen in IDLE leads to En=0 one cycle later.
- Burst with no stalls: BURST beat cycles, then 1 IDLE cycle before the next grant. Back-to-back throughput is BURST/(BURST+1).
- A demand change made in the same cycle as the last beat is evaluated in the following IDLE cycle.

## Structure
- Shared package demux_sched_pkg holds:
  - state enum {IDLE, GRANT}
  - NUM_SINKS=4
  - SEL_W=2
  - onehot/index helper functions
- Sub-module rr_arbiter4 is combinational. Inputs: req[3:0], ptr[1:0]. Outputs: gnt_idx[1:0], gnt_any.
- The demux itself is instantiated by the parent. This block never touches the data bit.

## Test plan
- Reset: hold rst 2 cycles, with req=1111 and in_valid=1 -> En=1, S=0, grant=0, in_ready=0, busy=0 throughout. After release, the first grant is sink 0.
- Single sink, BURST=4: req=0100, in_valid=1 -> next cycle S=2, En=0, grant=0100. Exactly 4 out_valid=0100 pulses follow, then En=1 and grant=0.
- Fairness: req=1111 constantly, in_valid=1 -> grants go 0,1,2,3,0. Each grant lasts 4 beats with one En=1 cycle between grants.
- Stall: sink 1 granted; req[1] drops after 2 beats for 3 cycles -> in_ready=0, no out_valid pulses, S=1 and En=0 held. After req[1] returns, 2 more beats, then IDLE.
- Source gaps: in_valid toggles 1,0,1,0 during a grant -> only the in_valid=1 cycles count. The burst ends after 4 valid beats, 8 cycles.
- Reset mid-burst: rst after beat 2 of a sink-3 burst -> next cycle all outputs are at reset values. With req=1001 afterwards, sink 0 is granted first.

Source files
------------

// File: rtl/demux_sched_pkg.sv
// Shared types and helpers for the demux burst scheduler and its arbiter.
package demux_sched_pkg;

  localparam int NUM_SINKS = 4;
  localparam int SEL_W     = 2;

  typedef enum logic {IDLE, GRANT} state_t;

  function automatic logic [NUM_SINKS-1:0] onehot(input logic [SEL_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  // Lowest set bit wins; intended for one-hot inputs.
  function automatic logic [SEL_W-1:0] index(input logic [NUM_SINKS-1:0] oh);
    index = '0;
    for (int i = NUM_SINKS - 1; i >= 0; i--) begin
      if (oh[i]) index = SEL_W'(i);
    end
  endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin pick: searches ptr+1, ptr+2, ptr+3, ptr.
module rr_arbiter4
  import demux_sched_pkg::*;
(
  input  logic [NUM_SINKS-1:0] req,
  input  logic [SEL_W-1:0]     ptr,
  output logic [SEL_W-1:0]     gnt_idx,
  output logic                 gnt_any
);

  logic [SEL_W-1:0] cand;

  // Walk the order from lowest priority up so the highest-priority hit is written last.
  always_comb begin
    gnt_any = |req;
    gnt_idx = '0;
    cand    = '0;
    for (int i = NUM_SINKS; i >= 1; i--) begin
      cand = ptr + SEL_W'(i);
      if (req[cand]) gnt_idx = cand;
    end
  end

endmodule

// File: rtl/demux_burst_scheduler.sv
// Round-robin burst scheduler driving a 1-to-4 demux select/enable and the source handshake.
module demux_burst_scheduler
  import demux_sched_pkg::*;
#(
  parameter int BURST = 4,
  localparam int CNT_W = $clog2(BURST + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_SINKS-1:0] req,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [SEL_W-1:0]     S,
  output logic                 En,
  output logic [NUM_SINKS-1:0] grant,
  output logic [NUM_SINKS-1:0] out_valid,
  output logic                 busy
);

  // Handshake: a bit moves from source to sink S exactly in cycles where
  // in_valid && in_ready; in_ready follows the granted sink's req with no delay.

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] arb_idx;
  logic             arb_any;
  logic             beat;

  rr_arbiter4 u_arb (
    .req     (req),
    .ptr     (ptr),
    .gnt_idx (arb_idx),
    .gnt_any (arb_any)
  );

  assign in_ready  = (state == GRANT) && req[S];
  assign beat      = in_valid && in_ready;
  assign out_valid = grant & {NUM_SINKS{beat}};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      En    <= 1'b1;
      S     <= '0;
      grant <= '0;
      busy  <= 1'b0;
      cnt   <= '0;
      ptr   <= SEL_W'(NUM_SINKS - 1);
    end else begin
      case (state)
        IDLE: begin
          if (arb_any) begin
            S     <= arb_idx;
            grant <= onehot(arb_idx);
            En    <= 1'b0;
            busy  <= 1'b1;
            cnt   <= '0;
            ptr   <= arb_idx;
            state <= GRANT;
          end
        end
        GRANT: begin
          // Stalls simply hold everything; the burst only closes on its last beat.
          if (beat) begin
            if (cnt == CNT_W'(BURST - 1)) begin
              state <= IDLE;
              En    <= 1'b1;
              grant <= '0;
              busy  <= 1'b0;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_demux_burst_scheduler.sv
// Directed bench for demux_burst_scheduler with BURST=4.
module tb_demux_burst_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] S;
  logic       En;
  logic [3:0] grant;
  logic [3:0] out_valid;
  logic       busy;

  int passed = 0;
  int total  = 0;

  demux_burst_scheduler #(.BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .S         (S),
    .En        (En),
    .grant     (grant),
    .out_valid (out_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp)
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    else
      passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_en"}, 32'(En), 32'd1);
    chk({tag, "_s"}, 32'(S), 32'd0);
    chk({tag, "_grant"}, 32'(grant), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
  endtask

  // Full no-stall burst to sink idx, ending in (not after) the IDLE cycle.
  task automatic expect_burst(input int idx);
    logic [3:0] oh;
    oh = 4'b0001 << idx;
    for (int b = 0; b < 4; b++) begin
      #1;
      chk("burst_grant", 32'(grant), 32'(oh));
      chk("burst_s", 32'(S), 32'(idx));
      chk("burst_en", 32'(En), 32'd0);
      chk("burst_busy", 32'(busy), 32'd1);
      chk("burst_out_valid", 32'(out_valid), 32'(oh));
      tick();
    end
    #1;
    chk("gap_en", 32'(En), 32'd1);
    chk("gap_grant", 32'(grant), 32'd0);
    chk("gap_busy", 32'(busy), 32'd0);
    chk("gap_in_ready", 32'(in_ready), 32'd0);
    chk("gap_s_hold", 32'(S), 32'(idx));
  endtask

  initial begin
    rst      = 1'b1;
    req      = 4'b1111;
    in_valid = 1'b1;
    repeat (2) begin
      tick();
      chk_reset_vals("reset");
    end
    rst = 1'b0;
    #1;
    chk("post_reset_idle_en", 32'(En), 32'd1);
    chk("post_reset_in_ready", 32'(in_ready), 32'd0);

    // Fairness with all sinks requesting.
    tick();
    expect_burst(0); tick();
    expect_burst(1); tick();
    expect_burst(2); tick();
    expect_burst(3); tick();
    expect_burst(0);

    // Single sink 2.
    req = 4'b0100;
    tick();
    expect_burst(2);
    req = 4'b0000;
    tick();
    #1;
    chk("idle_hold_busy", 32'(busy), 32'd0);
    chk("idle_hold_grant", 32'(grant), 32'd0);
    chk("idle_hold_en", 32'(En), 32'd1);

    // Stall on sink 1, with sink 3 requesting meanwhile (must be ignored).
    req = 4'b0010;
    tick();
    for (int b = 0; b < 2; b++) begin
      #1;
      chk("stall_pre_beat", 32'(out_valid), 32'h2);
      tick();
    end
    req = 4'b1000;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_out_valid", 32'(out_valid), 32'd0);
      chk("stall_s", 32'(S), 32'd1);
      chk("stall_en", 32'(En), 32'd0);
      chk("stall_grant", 32'(grant), 32'h2);
      tick();
    end
    req = 4'b0010;
    for (int b = 0; b < 2; b++) begin
      #1;
      chk("stall_post_beat", 32'(out_valid), 32'h2);
      tick();
    end
    #1;
    chk("stall_end_en", 32'(En), 32'd1);
    chk("stall_end_grant", 32'(grant), 32'd0);

    // Source gaps on sink 0: 4 valid beats over 8 cycles.
    req      = 4'b0001;
    in_valid = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      in_valid = (i % 2) == 1;
      #1;
      chk("gap_src_out_valid", 32'(out_valid), in_valid ? 32'h1 : 32'h0);
      chk("gap_src_en", 32'(En), 32'd0);
      tick();
    end
    #1;
    chk("gap_src_end_en", 32'(En), 32'd1);
    chk("gap_src_end_busy", 32'(busy), 32'd0);

    // Reset in the middle of a sink-3 burst.
    in_valid = 1'b1;
    req      = 4'b1000;
    tick();
    for (int b = 0; b < 2; b++) begin
      #1;
      chk("mid_grant", 32'(grant), 32'h8);
      chk("mid_out_valid", 32'(out_valid), 32'h8);
      tick();
    end
    rst = 1'b1;
    req = 4'b1001;
    tick();
    chk_reset_vals("mid_reset");
    rst = 1'b0;
    tick();
    expect_burst(0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
